// File: rtl/cpu_pkg.sv
// Shared widths and types for the ID/EX operand stage and its forwarding units.
package cpu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUCTRL_W  = 3;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic [ALUCTRL_W-1:0] aluctrl;
        logic                 alusrc;
        logic                 regwrite;
        logic                 memread;
        logic                 memwrite;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/forward_unit.sv
// Combinational RAW resolver for one source operand; the younger EX/MEM write beats MEM/WB.
module forward_unit #(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  exmem_regwrite,
    input  logic [DATA_WIDTH-1:0] exmem_result,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic                  memwb_regwrite,
    input  logic [DATA_WIDTH-1:0] memwb_result,
    input  logic [DATA_WIDTH-1:0] reg_data,
    output cpu_pkg::fwd_sel_t     fwd_sel,
    output logic [DATA_WIDTH-1:0] fwd_data
);
    import cpu_pkg::*;

    logic exmem_hit;
    logic memwb_hit;

    // x0 is hardwired to zero, so a write targeting it must never be forwarded.
    assign exmem_hit = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src_addr);
    assign memwb_hit = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src_addr);

    always_comb begin
        fwd_sel  = FWD_REG;
        fwd_data = reg_data;
        if (exmem_hit) begin
            fwd_sel  = FWD_EXMEM;
            fwd_data = exmem_result;
        end else if (memwb_hit) begin
            fwd_sel  = FWD_MEMWB;
            fwd_data = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall detection.
// Optional stall/flush performance counters are enabled with ID_EX_PERF_CNT_EN.
module id_ex_operand_stage #(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic                  id_alusrc,
    input  logic [2:0]            id_aluctrl,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_memwrite,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic                  exmem_regwrite,
    input  logic [DATA_WIDTH-1:0] exmem_result,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic                  memwb_regwrite,
    input  logic [DATA_WIDTH-1:0] memwb_result,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [2:0]            ALUctrl,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_regwrite,
    output logic                  ex_memread,
    output logic                  ex_memwrite
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);
    import cpu_pkg::*;

    logic                  ex_valid_q,    ex_valid_d;
    id_ex_ctrl_t           ex_ctrl_q,     ex_ctrl_d;
    logic [REG_ADDR_W-1:0] ex_rd_q,       ex_rd_d;
    logic [REG_ADDR_W-1:0] ex_rs1_addr_q, ex_rs1_addr_d;
    logic [REG_ADDR_W-1:0] ex_rs2_addr_q, ex_rs2_addr_d;
    logic [DATA_WIDTH-1:0] ex_rs1_data_q, ex_rs1_data_d;
    logic [DATA_WIDTH-1:0] ex_rs2_data_q, ex_rs2_data_d;
    logic [DATA_WIDTH-1:0] ex_imm_q,      ex_imm_d;

    logic                  load_use_hit;
    logic                  bubble;

    fwd_sel_t              rs1_fwd_sel;
    fwd_sel_t              rs2_fwd_sel;
    logic [DATA_WIDTH-1:0] rs1_fwd_data;
    logic [DATA_WIDTH-1:0] rs2_fwd_data;
    logic                  unused_fwd_sel;

    // A load in EX only has its data at the end of MEM, so a dependent instruction must wait one cycle.
    assign load_use_hit = ex_valid_q && ex_ctrl_q.memread && (ex_rd_q != '0) &&
                          ((ex_rd_q == id_rs1_addr) || (ex_rd_q == id_rs2_addr));
    assign stall        = id_valid && load_use_hit;
    assign bubble       = flush || stall;

    always_comb begin
        ex_valid_d    = id_valid;
        ex_ctrl_d     = '{aluctrl:  id_aluctrl,
                          alusrc:   id_alusrc,
                          regwrite: id_regwrite,
                          memread:  id_memread,
                          memwrite: id_memwrite};
        ex_rd_d       = id_rd_addr;
        ex_rs1_addr_d = id_rs1_addr;
        ex_rs2_addr_d = id_rs2_addr;
        ex_rs1_data_d = id_rs1_data;
        ex_rs2_data_d = id_rs2_data;
        ex_imm_d      = id_imm;
        // Bubble clears the source indices too, so an empty slot can never trigger a forward.
        if (bubble) begin
            ex_valid_d    = 1'b0;
            ex_ctrl_d     = CTRL_BUBBLE;
            ex_rd_d       = '0;
            ex_rs1_addr_d = '0;
            ex_rs2_addr_d = '0;
            ex_rs1_data_d = '0;
            ex_rs2_data_d = '0;
            ex_imm_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_ctrl_q     <= CTRL_BUBBLE;
            ex_rd_q       <= '0;
            ex_rs1_addr_q <= '0;
            ex_rs2_addr_q <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_ctrl_q     <= ex_ctrl_d;
            ex_rd_q       <= ex_rd_d;
            ex_rs1_addr_q <= ex_rs1_addr_d;
            ex_rs2_addr_q <= ex_rs2_addr_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
        end
    end

    forward_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs1 (
        .src_addr       (ex_rs1_addr_q),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .exmem_result   (exmem_result),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_result   (memwb_result),
        .reg_data       (ex_rs1_data_q),
        .fwd_sel        (rs1_fwd_sel),
        .fwd_data       (rs1_fwd_data)
    );

    forward_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs2 (
        .src_addr       (ex_rs2_addr_q),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .exmem_result   (exmem_result),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_result   (memwb_result),
        .reg_data       (ex_rs2_data_q),
        .fwd_sel        (rs2_fwd_sel),
        .fwd_data       (rs2_fwd_data)
    );

    // Select codes are kept for debug visibility; the datapath uses the resolved data directly.
    assign unused_fwd_sel = ^{rs1_fwd_sel, rs2_fwd_sel};

    assign ex_valid      = ex_valid_q;
    assign ALUop1        = rs1_fwd_data;
    assign ALUop2        = ex_ctrl_q.alusrc ? ex_imm_q : rs2_fwd_data;
    assign ex_store_data = rs2_fwd_data;
    assign ALUctrl       = ex_ctrl_q.aluctrl;
    assign ex_rd         = ex_rd_q;
    assign ex_regwrite   = ex_valid_q && ex_ctrl_q.regwrite;
    assign ex_memread    = ex_valid_q && ex_ctrl_q.memread;
    assign ex_memwrite   = ex_valid_q && ex_ctrl_q.memwrite;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'b0, stall};
        flush_cnt_d = flush_cnt_q + {31'b0, flush};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
